// File: rtl/ctrl_redirect_sched_pkg.sv
// Shared constants, FSM encodings, update-record type and age compare
// for the control-ALU redirect scheduler.
package ctrl_redirect_sched_pkg;

  localparam int SIZE_PC      = 32;
  localparam int SIZE_AL_LOG  = 7;
  localparam int TAG_W        = SIZE_AL_LOG + 1;
  localparam int FLAG_MISPRED = 0;
  localparam int FLAG_CTRL    = 5;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  typedef struct packed {
    logic [SIZE_PC-1:0] pc;
    logic [SIZE_PC-1:0] target;
    logic               dir;
  } upd_rec_t;

  // Tag MSB is the wrap bit: once the active list has wrapped, index order flips.
  function automatic logic is_older(input logic [TAG_W-1:0] tag_a,
                                    input logic [TAG_W-1:0] tag_b);
    logic older;
    if (tag_a[TAG_W-1] == tag_b[TAG_W-1]) begin
      older = (tag_a[SIZE_AL_LOG-1:0] < tag_b[SIZE_AL_LOG-1:0]);
    end else begin
      older = (tag_a[SIZE_AL_LOG-1:0] > tag_b[SIZE_AL_LOG-1:0]);
    end
    return older;
  endfunction

endpackage

// File: rtl/ctrl_redirect_sched_chk.sv
// Protocol checks for the redirect scheduler: no record dropped on a full
// FIFO, and flush always accompanies redirect.
module ctrl_redirect_sched_chk (
  input logic clk,
  input logic reset,
  input logic overflow_i,
  input logic redirect_i,
  input logic flush_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !overflow_i);
  a_redirect_flush: assert property (@(posedge clk) disable iff (!reset) redirect_i == flush_i);

endmodule

// File: rtl/ctrl_upd_fifo.sv
// Multi-push, single-pop FIFO of predictor-update records. Same-cycle pushes
// are packed in lane order; pushes beyond the free space are dropped.
module ctrl_upd_fifo
  import ctrl_redirect_sched_pkg::*;
#(
  parameter int NUM_PUSH = 2,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_PUSH-1:0] push_i,
  input  upd_rec_t            push_data_i [NUM_PUSH],
  input  logic                pop_i,
  output logic                valid_o,
  output upd_rec_t            head_o,
  output logic                stall_o,
  output logic                overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  upd_rec_t            mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                stall_q, stall_d;
  logic [NUM_PUSH-1:0] wr_en_s;
  logic [PTR_W-1:0]    wr_idx_s [NUM_PUSH];
  logic                pop_s;
  logic [CNT_W-1:0]    free_s;
  logic [CNT_W-1:0]    n_push_s;

  // Slot allocation; a pop this cycle frees the head slot for a same-cycle push.
  always_comb begin
    pop_s      = pop_i & (count_q != '0);
    free_s     = CNT_W'(DEPTH) - count_q + CNT_W'(pop_s);
    n_push_s   = '0;
    overflow_o = 1'b0;
    wr_en_s    = '0;
    for (int p = 0; p < NUM_PUSH; p++) begin
      wr_idx_s[p] = wr_ptr_q + n_push_s[PTR_W-1:0];
      if (push_i[p] && (n_push_s < free_s)) begin
        wr_en_s[p] = 1'b1;
        n_push_s   = n_push_s + CNT_W'(1);
      end else begin
        wr_en_s[p] = 1'b0;
        overflow_o = overflow_o | push_i[p];
      end
    end
    count_d  = count_q + n_push_s - CNT_W'(pop_s);
    wr_ptr_d = wr_ptr_q + n_push_s[PTR_W-1:0];
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
    stall_d  = ((CNT_W'(DEPTH) - count_d) < CNT_W'(NUM_PUSH));
  end

  // Pointer, occupancy and stall state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PUSH; p++) begin
      if (wr_en_s[p]) begin
        mem_q[wr_idx_s[p]] <= push_data_i[p];
      end
    end
  end

  // Head is presented directly; zeroed while empty so stale entries never show.
  always_comb begin
    valid_o = (count_q != '0);
    if (valid_o) begin
      head_o = mem_q[rd_ptr_q];
    end else begin
      head_o = '0;
    end
  end

  assign stall_o = stall_q;

endmodule

// File: rtl/ctrl_redirect_sched.sv
// Picks the oldest mispredicting control lane, sequences redirect/flush/recovery
// and queues predictor-update records for fetch.
module ctrl_redirect_sched
  import ctrl_redirect_sched_pkg::*;
#(
  parameter int NUM_LANES    = 2,
  parameter int FLUSH_CYCLES = 3,
  parameter int UPD_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_LANES-1:0]         exeValid_i,
  input  logic [NUM_LANES*TAG_W-1:0]   exeAlTag_i,
  input  logic [NUM_LANES*SIZE_PC-1:0] exePC_i,
  input  logic [NUM_LANES*SIZE_PC-1:0] exeNextPC_i,
  input  logic [NUM_LANES-1:0]         exeDir_i,
  input  logic [NUM_LANES*8-1:0]       exeFlags_i,
  input  logic                         updReady_i,
  output logic                         redirect_o,
  output logic [SIZE_PC-1:0]           redirectPC_o,
  output logic                         flush_o,
  output logic [TAG_W-1:0]             flushTag_o,
  output logic                         recoverDone_o,
  output logic                         ctrlStall_o,
  output logic                         updValid_o,
  output logic [SIZE_PC-1:0]           updPC_o,
  output logic [SIZE_PC-1:0]           updTarget_o,
  output logic                         updDir_o
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  logic [TAG_W-1:0]     lane_tag_s [NUM_LANES];
  upd_rec_t             lane_rec_s [NUM_LANES];
  logic [NUM_LANES-1:0] cand_s, elig_s, push_s;
  logic                 win_valid_s;
  logic [TAG_W-1:0]     win_tag_s;
  logic [SIZE_PC-1:0]   win_npc_s;
  logic                 older_win_s;
  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TAG_W-1:0]     cap_tag_q, cap_tag_d;
  logic [SIZE_PC-1:0]   cap_pc_q, cap_pc_d;
  logic                 redirect_q, flush_q, done_q, done_d;
  logic                 fifo_valid_s, fifo_overflow_s, fifo_stall_s;
  upd_rec_t             fifo_head_s;
  logic                 unused_flags_s;

  assign unused_flags_s = ^exeFlags_i;

  // Lane unpacking; a mispredicting lane always counts as update-eligible.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_tag_s[l]        = exeAlTag_i[l*TAG_W +: TAG_W];
      lane_rec_s[l].pc     = exePC_i[l*SIZE_PC +: SIZE_PC];
      lane_rec_s[l].target = exeNextPC_i[l*SIZE_PC +: SIZE_PC];
      lane_rec_s[l].dir    = exeDir_i[l];
      cand_s[l] = exeValid_i[l] & exeFlags_i[l*8 + FLAG_MISPRED];
      elig_s[l] = exeValid_i[l] &
                  (exeFlags_i[l*8 + FLAG_CTRL] | exeFlags_i[l*8 + FLAG_MISPRED]);
    end
  end

  // Oldest-candidate select; only a strictly older lane displaces, so ties keep the lower lane.
  always_comb begin
    win_valid_s = 1'b0;
    win_tag_s   = '0;
    win_npc_s   = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (cand_s[l] && (!win_valid_s || is_older(lane_tag_s[l], win_tag_s))) begin
        win_valid_s = 1'b1;
        win_tag_s   = lane_tag_s[l];
        win_npc_s   = lane_rec_s[l].target;
      end else begin
        win_valid_s = win_valid_s;
      end
    end
    older_win_s = win_valid_s & is_older(win_tag_s, cap_tag_q);
  end

  // Update enqueue filter: nothing younger than the branch being recovered.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      case (state_q)
        ST_IDLE:     push_s[l] = elig_s[l] & ~(win_valid_s & is_older(win_tag_s, lane_tag_s[l]));
        ST_REDIRECT: push_s[l] = elig_s[l] & is_older(lane_tag_s[l], cap_tag_q);
        ST_FLUSH:    push_s[l] = elig_s[l] & is_older(lane_tag_s[l], cap_tag_q);
        default:     push_s[l] = 1'b0;
      endcase
    end
  end

  // Recovery FSM; an older mispredict during recovery restarts it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_tag_d = cap_tag_q;
    cap_pc_d  = cap_pc_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s) begin
          cap_tag_d = win_tag_s;
          cap_pc_d  = win_npc_s;
          state_d   = ST_REDIRECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        cnt_d = CNT_LOAD;
        if (older_win_s) begin
          cap_tag_d = win_tag_s;
          cap_pc_d  = win_npc_s;
          state_d   = ST_REDIRECT;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (older_win_s) begin
          cap_tag_d = win_tag_s;
          cap_pc_d  = win_npc_s;
          state_d   = ST_REDIRECT;
        end else if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, capture registers and registered control pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cap_tag_q  <= '0;
      cap_pc_q   <= '0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_tag_q  <= cap_tag_d;
      cap_pc_q   <= cap_pc_d;
      redirect_q <= (state_d == ST_REDIRECT);
      flush_q    <= (state_d == ST_REDIRECT);
      done_q     <= done_d;
    end
  end

  ctrl_upd_fifo #(
    .NUM_PUSH (NUM_LANES),
    .DEPTH    (UPD_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_data_i (lane_rec_s),
    .pop_i       (updReady_i),
    .valid_o     (fifo_valid_s),
    .head_o      (fifo_head_s),
    .stall_o     (fifo_stall_s),
    .overflow_o  (fifo_overflow_s)
  );

  ctrl_redirect_sched_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .overflow_i (fifo_overflow_s),
    .redirect_i (redirect_q),
    .flush_i    (flush_q)
  );

  assign redirect_o    = redirect_q;
  assign flush_o       = flush_q;
  assign redirectPC_o  = cap_pc_q;
  assign flushTag_o    = cap_tag_q;
  assign recoverDone_o = done_q;
  assign ctrlStall_o   = fifo_stall_s;
  assign updValid_o    = fifo_valid_s;
  assign updPC_o       = fifo_head_s.pc;
  assign updTarget_o   = fifo_head_s.target;
  assign updDir_o      = fifo_head_s.dir;

endmodule

// File: tb/tb_ctrl_redirect_sched.sv
// Bench for ctrl_redirect_sched: vector table for winner select and update
// filtering, hand sequences for re-redirect, FIFO backpressure and reset.
module tb_ctrl_redirect_sched;
  import ctrl_redirect_sched_pkg::*;

  localparam int FC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  exeValid_i;
  logic [15:0] exeAlTag_i;
  logic [63:0] exePC_i, exeNextPC_i;
  logic [1:0]  exeDir_i;
  logic [15:0] exeFlags_i;
  logic        updReady_i;
  logic        redirect_o, flush_o, recoverDone_o, ctrlStall_o, updValid_o, updDir_o;
  logic [31:0] redirectPC_o, updPC_o, updTarget_o;
  logic [7:0]  flushTag_o;

  always #5 clk = ~clk;

  ctrl_redirect_sched #(.NUM_LANES(2), .FLUSH_CYCLES(FC), .UPD_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .exeValid_i(exeValid_i), .exeAlTag_i(exeAlTag_i),
    .exePC_i(exePC_i), .exeNextPC_i(exeNextPC_i), .exeDir_i(exeDir_i),
    .exeFlags_i(exeFlags_i), .updReady_i(updReady_i), .redirect_o(redirect_o),
    .redirectPC_o(redirectPC_o), .flush_o(flush_o), .flushTag_o(flushTag_o),
    .recoverDone_o(recoverDone_o), .ctrlStall_o(ctrlStall_o), .updValid_o(updValid_o),
    .updPC_o(updPC_o), .updTarget_o(updTarget_o), .updDir_o(updDir_o)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [7:0]  tag0, tag1;
    logic [31:0] npc0, npc1;
    logic [1:0]  dir;
    logic [7:0]  flg0, flg1;
    logic        exp_redir;
    logic [31:0] exp_pc;
    logic [7:0]  exp_tag;
    logic [1:0]  exp_push;
  } vec_t;

  int       n_tests = 0;
  int       n_fail  = 0;
  upd_rec_t sb_q[$];
  upd_rec_t mon_rec;
  vec_t     vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [7:0] t0, input logic [7:0] t1,
                              input logic [31:0] n0, input logic [31:0] n1, input logic [1:0] d,
                              input logic [7:0] f0, input logic [7:0] f1, input logic er,
                              input logic [31:0] epc, input logic [7:0] etag, input logic [1:0] ep);
    vec_t r;
    r.valid = v; r.tag0 = t0; r.tag1 = t1; r.npc0 = n0; r.npc1 = n1; r.dir = d;
    r.flg0 = f0; r.flg1 = f1; r.exp_redir = er; r.exp_pc = epc; r.exp_tag = etag; r.exp_push = ep;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    exeValid_i = '0; exeAlTag_i = '0; exePC_i = '0; exeNextPC_i = '0; exeDir_i = '0; exeFlags_i = '0;
  endtask

  task automatic drive_lane(input int l, input logic [7:0] tag, input logic [31:0] pc,
                            input logic [31:0] npc, input logic dir, input logic [7:0] flg,
                            input logic vld);
    exeValid_i[l] = vld;
    exeAlTag_i[l*8 +: 8] = tag;
    exePC_i[l*32 +: 32] = pc;
    exeNextPC_i[l*32 +: 32] = npc;
    exeDir_i[l] = dir;
    exeFlags_i[l*8 +: 8] = flg;
  endtask

  task automatic expect_rec(input logic [31:0] pc, input logic [31:0] npc, input logic dir);
    upd_rec_t r;
    r.pc = pc; r.target = npc; r.dir = dir;
    sb_q.push_back(r);
  endtask

  // Scoreboard side: each accepted record must match the oldest expected one.
  always @(negedge clk) begin
    if (reset && updValid_o && updReady_i) begin
      if (sb_q.size() == 0) begin
        check("upd_unexpected", 64'd1, 64'd0);
      end else begin
        mon_rec = sb_q.pop_front();
        check("upd_pc", 64'(updPC_o), 64'(mon_rec.pc));
        check("upd_target", 64'(updTarget_o), 64'(mon_rec.target));
        check("upd_dir", 64'(updDir_o), 64'(mon_rec.dir));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc0, pc1;
    int done_at, done_cnt;

    //          valid  tag0   tag1   npc0          npc1          dir    flg0   flg1   redir exp_pc        exp_tag push
    vecs[0] = mk(2'b01, 8'h05, 8'h00, 32'h0040_0100, 32'h0,        2'b01, 8'h21, 8'h00, 1'b1, 32'h0040_0100, 8'h05, 2'b01);
    vecs[1] = mk(2'b11, 8'h09, 8'h03, 32'h0050_0000, 32'h0050_0200, 2'b11, 8'h21, 8'h21, 1'b1, 32'h0050_0200, 8'h03, 2'b10);
    vecs[2] = mk(2'b11, 8'h82, 8'h7E, 32'h0060_0000, 32'h0060_0400, 2'b00, 8'h21, 8'h21, 1'b1, 32'h0060_0400, 8'h7E, 2'b10);
    vecs[3] = mk(2'b11, 8'h10, 8'h11, 32'h0070_0000, 32'h0070_0100, 2'b10, 8'h20, 8'h20, 1'b0, 32'h0,        8'h00, 2'b11);
    vecs[4] = mk(2'b11, 8'h28, 8'h32, 32'h0080_0000, 32'h0080_0800, 2'b01, 8'h20, 8'h21, 1'b1, 32'h0080_0800, 8'h32, 2'b11);
    vecs[5] = mk(2'b11, 8'h07, 8'h07, 32'h0090_0000, 32'h0090_0900, 2'b10, 8'h21, 8'h21, 1'b1, 32'h0090_0000, 8'h07, 2'b11);
    vecs[6] = mk(2'b10, 8'h0C, 8'h0D, 32'h00A0_0000, 32'h00A0_0100, 2'b11, 8'h21, 8'h00, 1'b0, 32'h0,        8'h00, 2'b00);
    vecs[7] = mk(2'b11, 8'h78, 8'h81, 32'h00B0_0000, 32'h00B0_0100, 2'b01, 8'h21, 8'h21, 1'b1, 32'h00B0_0000, 8'h78, 2'b01);

    reset = 1'b0; updReady_i = 1'b1; clear_lanes();
    repeat (3) tick();
    check("rst_redirect", 64'(redirect_o), 64'd0);
    check("rst_flush", 64'(flush_o), 64'd0);
    check("rst_done", 64'(recoverDone_o), 64'd0);
    check("rst_stall", 64'(ctrlStall_o), 64'd0);
    check("rst_updvalid", 64'(updValid_o), 64'd0);
    check("rst_redirpc", 64'(redirectPC_o), 64'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      pc0 = 32'h0001_0000 + 32'(i) * 32'h100;
      pc1 = pc0 + 32'd4;
      drive_lane(0, vecs[i].tag0, pc0, vecs[i].npc0, vecs[i].dir[0], vecs[i].flg0, vecs[i].valid[0]);
      drive_lane(1, vecs[i].tag1, pc1, vecs[i].npc1, vecs[i].dir[1], vecs[i].flg1, vecs[i].valid[1]);
      if (vecs[i].exp_push[0]) expect_rec(pc0, vecs[i].npc0, vecs[i].dir[0]);
      if (vecs[i].exp_push[1]) expect_rec(pc1, vecs[i].npc1, vecs[i].dir[1]);
      tick();
      clear_lanes();
      check($sformatf("v%0d_redirect", i), 64'(redirect_o), 64'(vecs[i].exp_redir));
      check($sformatf("v%0d_flush", i), 64'(flush_o), 64'(vecs[i].exp_redir));
      if (vecs[i].exp_redir) begin
        check($sformatf("v%0d_redir_pc", i), 64'(redirectPC_o), 64'(vecs[i].exp_pc));
        check($sformatf("v%0d_flush_tag", i), 64'(flushTag_o), 64'(vecs[i].exp_tag));
        done_at = 0; done_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
          tick();
          if (recoverDone_o) begin
            done_cnt++;
            if (done_at == 0) done_at = k;
          end
        end
        check($sformatf("v%0d_done_latency", i), 64'(done_at), 64'(1 + FC));
        check($sformatf("v%0d_done_pulses", i), 64'(done_cnt), 64'd1);
      end else begin
        repeat (3) tick();
      end
    end

    // Older mispredict during FLUSH re-redirects; a younger one is ignored.
    drive_lane(0, 8'h14, 32'h0B00_0000, 32'h00B0_0000, 1'b1, 8'h21, 1'b1);
    expect_rec(32'h0B00_0000, 32'h00B0_0000, 1'b1);
    tick(); clear_lanes();
    check("s4_redirect1", 64'(redirect_o), 64'd1);
    check("s4_tag1", 64'(flushTag_o), 64'h14);
    tick();
    check("s4_flush_no_redirect", 64'(redirect_o), 64'd0);
    drive_lane(1, 8'h0A, 32'h0B10_0000, 32'h00B1_1000, 1'b0, 8'h21, 1'b1);
    expect_rec(32'h0B10_0000, 32'h00B1_1000, 1'b0);
    tick(); clear_lanes();
    check("s4_redirect2", 64'(redirect_o), 64'd1);
    check("s4_pc2", 64'(redirectPC_o), 64'h00B1_1000);
    check("s4_tag2", 64'(flushTag_o), 64'h0A);
    tick();
    drive_lane(0, 8'h1E, 32'h0B20_0000, 32'h00B2_2000, 1'b1, 8'h21, 1'b1);
    tick(); clear_lanes();
    check("s4_young_ignored", 64'(redirect_o), 64'd0);
    check("s4_pc_held", 64'(redirectPC_o), 64'h00B1_1000);
    check("s4_no_early_done", 64'(recoverDone_o), 64'd0);
    tick();
    check("s4_done_not_yet", 64'(recoverDone_o), 64'd0);
    tick();
    check("s4_done", 64'(recoverDone_o), 64'd1);
    tick();
    check("s4_done_single", 64'(recoverDone_o), 64'd0);
    repeat (3) tick();

    // FIFO fill under backpressure, then drain in order.
    updReady_i = 1'b0;
    drive_lane(0, 8'h01, 32'h0C00_0000, 32'h0C00_1000, 1'b1, 8'h20, 1'b1);
    drive_lane(1, 8'h02, 32'h0C00_0004, 32'h0C00_2000, 1'b0, 8'h20, 1'b1);
    expect_rec(32'h0C00_0000, 32'h0C00_1000, 1'b1);
    expect_rec(32'h0C00_0004, 32'h0C00_2000, 1'b0);
    tick(); clear_lanes();
    check("s5_stall_half", 64'(ctrlStall_o), 64'd0);
    check("s5_head_nobubble", 64'(updPC_o), 64'h0C00_0000);
    drive_lane(0, 8'h03, 32'h0C00_0008, 32'h0C00_3000, 1'b1, 8'h20, 1'b1);
    drive_lane(1, 8'h04, 32'h0C00_000C, 32'h0C00_4000, 1'b1, 8'h20, 1'b1);
    expect_rec(32'h0C00_0008, 32'h0C00_3000, 1'b1);
    expect_rec(32'h0C00_000C, 32'h0C00_4000, 1'b1);
    tick(); clear_lanes();
    check("s5_stall_full", 64'(ctrlStall_o), 64'd1);
    tick();
    check("s5_stall_hold", 64'(ctrlStall_o), 64'd1);
    check("s5_head_hold", 64'(updPC_o), 64'h0C00_0000);
    updReady_i = 1'b1;
    tick();
    check("s5_stall_3left", 64'(ctrlStall_o), 64'd1);
    tick();
    check("s5_stall_drop", 64'(ctrlStall_o), 64'd0);
    repeat (2) tick();
    check("s5_empty", 64'(updValid_o), 64'd0);

    // Reset during FLUSH aborts recovery and empties the FIFO.
    updReady_i = 1'b0;
    drive_lane(0, 8'h40, 32'h0D00_0000, 32'h00D0_0000, 1'b1, 8'h21, 1'b1);
    expect_rec(32'h0D00_0000, 32'h00D0_0000, 1'b1);
    tick(); clear_lanes();
    tick();
    check("s6_pre_valid", 64'(updValid_o), 64'd1);
    reset = 1'b0;
    sb_q.delete();
    tick();
    check("s6_redirect", 64'(redirect_o), 64'd0);
    check("s6_flush", 64'(flush_o), 64'd0);
    check("s6_redirpc", 64'(redirectPC_o), 64'd0);
    check("s6_flushtag", 64'(flushTag_o), 64'd0);
    check("s6_done", 64'(recoverDone_o), 64'd0);
    check("s6_stall", 64'(ctrlStall_o), 64'd0);
    check("s6_updvalid", 64'(updValid_o), 64'd0);
    check("s6_upd_rec", 64'({updPC_o, updTarget_o} ^ {63'd0, updDir_o}), 64'd0);
    reset = 1'b1; updReady_i = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (recoverDone_o) done_cnt++;
    end
    check("s6_no_done", 64'(done_cnt), 64'd0);
    check("s6_still_empty", 64'(updValid_o), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
